// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and width helpers for the hazard/forwarding controller.
package hazard_forward_unit_pkg;

  // Widest register index a shadow slot can hold (NREG up to 256).
  localparam int unsigned RdMaxW = 8;

  // Operand select value meaning "take the register file".
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [RdMaxW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  function automatic int unsigned rw_of(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int unsigned fw_of(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

  // x0 is hardwired, so a write to it never produces a usable value.
  function automatic logic slot_writes(input slot_t s, input logic [RdMaxW-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side signal bundle of the hazard/forwarding controller.
interface hazard_forward_unit_if
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned NREG       = 32,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned CNT_W      = 32
) ();
  localparam int unsigned RW = rw_of(NREG);
  localparam int unsigned FW = fw_of(FWD_STAGES);

  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          ex_branch_taken;
  logic          mem_stall;

  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic             stall;
  logic             flush_ifid;
  logic             flush_idex;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: drives ID/EX status, consumes selects and hazard controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread,
    output ex_branch_taken, mem_stall,
    input  fwd_a, fwd_b, stall, flush_ifid, flush_idex, stall_count, flush_count
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_memread,
    input  ex_branch_taken, mem_stall,
    output fwd_a, fwd_b, stall, flush_ifid, flush_idex, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority match of one EX source register against the post-EX shadow slots.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned RW         = 5,
  parameter int unsigned FW         = 2
) (
  input  slot_t [FWD_STAGES:1] slots_i,
  input  logic  [RW-1:0]       src_i,
  input  logic                 use_i,
  output logic  [FW-1:0]       sel_o
);

  // Scan oldest to youngest so the youngest writer sets the select last.
  always_comb begin
    sel_o = FW'(FWD_RF);
    if (use_i) begin
      for (int s = FWD_STAGES; s >= 1; s--) begin
        if (slot_writes(slots_i[s], RdMaxW'(src_i))) begin
          sel_o = FW'(s);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the in-order pipeline, driven by a
// shadow pipeline of destination tags from EX through the last forwarding stage.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NREG       = 32,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_unit_if.slave bus
);

  localparam int unsigned RW      = rw_of(NREG);
  localparam int unsigned FW      = fw_of(FWD_STAGES);
  localparam int unsigned CntSatW = (CNT_W < XLEN) ? CNT_W : XLEN;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}} >> (CNT_W - CntSatW);

  slot_t [FWD_STAGES:0] slots_q, slots_d;
  logic  [RW-1:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic                 use1_q, use1_d, use2_q, use2_d;
  logic  [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [FW-1:0] sel_a, sel_b;
  logic          load_use, flush, stall, issue;

  // True when the youngest writer of r among slots 0..LOAD_LAT-1 is a load.
  function automatic logic load_hazard(input slot_t [FWD_STAGES:0] sl, input logic [RW-1:0] r);
    logic found, hit;
    found = 1'b0;
    hit   = 1'b0;
    for (int unsigned s = 0; s < LOAD_LAT; s++) begin
      if (!found && slot_writes(sl[s], RdMaxW'(r))) begin
        found = 1'b1;
        hit   = sl[s].memread;
      end
    end
    return hit;
  endfunction

  hazard_forward_unit_fwd_select #(
    .FWD_STAGES (FWD_STAGES),
    .RW         (RW),
    .FW         (FW)
  ) u_sel_a (
    .slots_i (slots_q[FWD_STAGES:1]),
    .src_i   (rs1_q),
    .use_i   (use1_q),
    .sel_o   (sel_a)
  );

  hazard_forward_unit_fwd_select #(
    .FWD_STAGES (FWD_STAGES),
    .RW         (RW),
    .FW         (FW)
  ) u_sel_b (
    .slots_i (slots_q[FWD_STAGES:1]),
    .src_i   (rs2_q),
    .use_i   (use2_q),
    .sel_o   (sel_b)
  );

  // Hazard decisions: freeze dominates, then a taken branch, then load-use.
  always_comb begin
    load_use = bus.id_valid &&
               ((bus.id_use_rs1 && load_hazard(slots_q, bus.id_rs1)) ||
                (bus.id_use_rs2 && load_hazard(slots_q, bus.id_rs2)));
    flush    = !reset && !bus.mem_stall && bus.ex_branch_taken && slots_q[0].valid;
    stall    = !reset && (bus.mem_stall || (load_use && !flush));
    issue    = bus.id_valid && !stall && !flush;
  end

  // Shadow shift: everything holds under freeze; slot 0 takes ID or a bubble.
  always_comb begin
    slots_d = slots_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    use1_d  = use1_q;
    use2_d  = use2_q;
    if (!bus.mem_stall) begin
      for (int s = FWD_STAGES; s >= 1; s--) begin
        slots_d[s] = slots_q[s-1];
      end
      if (issue) begin
        slots_d[0].valid    = 1'b1;
        slots_d[0].rd       = RdMaxW'(bus.id_rd);
        slots_d[0].regwrite = bus.id_regwrite;
        slots_d[0].memread  = bus.id_memread;
        rs1_d               = bus.id_rs1;
        rs2_d               = bus.id_rs2;
        use1_d              = bus.id_use_rs1;
        use2_d              = bus.id_use_rs2;
      end else begin
        // Bubble use bits cleared so a dead slot 0 never selects a forward.
        slots_d[0] = '0;
        use1_d     = 1'b0;
        use2_d     = 1'b0;
      end
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with asynchronous reset to an empty pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      use1_q      <= use1_d;
      use2_q      <= use2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_a       = reset ? FW'(FWD_RF) : sel_a;
  assign bus.fwd_b       = reset ? FW'(FWD_RF) : sel_b;
  assign bus.stall       = stall;
  assign bus.flush_ifid  = flush;
  assign bus.flush_idex  = flush;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard-detection and forwarding controller for the in-order RISC-V pipeline. It keeps its own shadow pipeline of destination-register tags from EX through the last forwarding stage, and from it derives ALU operand forwarding selects, load-use stalls, branch flushes and a global freeze. It generalises the fixed two-source EX/MEM–MEM/WB forwarding to FWD_STAGES sources with configurable load latency, and adds performance counters. It sits beside the ID/EX register and drives the operand muxes, the PC/IF-ID hold enables and the IF-ID/ID-EX flushes.

## Interface
- XLEN, 64: datapath width; sets only the counter saturation width cap.
- NREG, 32: architectural register count; RW = clog2(NREG).
- FWD_STAGES, 2: number of post-EX stages that can forward (stage 1 = MEM, stage 2 = WB, …); must be ≥ LOAD_LAT+1.
- LOAD_LAT, 1: stages after EX before load data exists; the load result can be forwarded from stage ≥ 1+LOAD_LAT.
- CNT_W, 32: performance counter width, ≤ XLEN.
- FW = clog2(FWD_STAGES+1): derived select width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  RW  ID source registers.
- id_use_rs1, id_use_rs2  in  1  the source is actually read.
- id_rd  in  RW  ID destination register.
- id_regwrite, id_memread  in  1  ID writes rd / is a load.
- ex_branch_taken  in  1  resolved taken branch or jump in EX.
- mem_stall  in  1  external freeze (data-memory busy).
- fwd_a, fwd_b  out  FW  EX operand select: 0 = register file, k = stage k result.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush_ifid, flush_idex  out  1  squash the IF/ID or ID/EX contents.
- stall_count, flush_count  out  CNT_W  saturating event counters.

## Operation
- Shadow slot s, s = 0 (EX) to FWD_STAGES, holds {valid, rd, regwrite, memread}. Slot 0 also holds rs1/rs2 and their use bits.
- A slot "writes r" when valid && regwrite && rd == r && r != 0. x0 never matches.
- Forwarding for the slot-0 source rsX: k = the smallest s in 1..FWD_STAGES that writes rsX. fwd = k, or 0 if there is no match or the use bit is clear. The youngest writer wins.
- Load-use: stall = 1 if id_valid, the ID source is used, and some slot j < LOAD_LAT writes that source with memread = 1 and is the youngest writer of it. Slot j must also be the youngest writer of that source across slots 0..j.
- Branch: ex_branch_taken && slot0.valid gives flush_ifid = flush_idex = 1, and stall is forced to 0. Flush beats load-use.
- Freeze: mem_stall = 1 gives stall = 1. The shadow state holds, flushes are forced to 0, and fwd outputs still reflect the held state.
- Advance when mem_stall = 0: slot s+1 ← slot s.
  - Slot 0 ← ID fields when the ID instruction is issued.
  - Slot 0 ← bubble (valid = 0) when stall or flush_idex is asserted, or id_valid = 0.
- stall_count increments on each cycle with stall = 1, including mem_stall cycles. flush_count increments on each flush_idex pulse. Both counters saturate at all-ones.

## Timing
- On reset (async) and while reset is held:
  - all slots invalid;
  - fwd_a = fwd_b = 0;
  - stall = 0, flushes = 0;
  - counters = 0.
- fwd_*, stall and flush_* are combinational from registered slots plus same-cycle ID/EX inputs. They are valid in the cycle the consumer sits in EX/ID.
- The shadow shift and counters update on the rising edge.
- A load-use stall lasts exactly LOAD_LAT − j cycles for a youngest matching load in slot j. For the default parameters this is 1 cycle.
- Reset asserted mid-stall or mid-flush drops all outputs immediately. The first post-reset cycle behaves as an empty pipeline.
- Simultaneous mem_stall and ex_branch_taken: freeze wins. The flush is taken in the first cycle after mem_stall falls, because slot 0 is still valid then.

## Structure
- A shared package holds the slot struct type {valid, rd, regwrite, memread}, the FW/RW derivations, and the named constant FWD_RF = 0.
- One natural sub-module, `fwd_select`: a combinational priority match of one source against slots 1..FWD_STAGES. It is instantiated twice, for rs1 and rs2.

## Test plan
- add x5 ← …, then the next instruction uses rs1 = x5 → fwd_a = 1 in its EX cycle. One cycle later the consumer uses rs2 = x5 → fwd_b = 2.
- A double write (x5 in slot 1 and slot 2) → fwd = 1 (youngest wins). A write to rd = 0 with a use of x0 → fwd = 0.
- A load to x6 is followed immediately by a use of x6 (defaults) → stall = 1 for exactly 1 cycle, then fwd = 2. stall_count goes 0 → 1.
- A load-use stall coincides with ex_branch_taken → stall = 0, both flushes = 1, flush_count = 1. The next cycle has slot 0 invalid.
- mem_stall is held for 3 cycles with a producer in slot 1 → fwd stays at 1, stall = 1 throughout, stall_count += 3, and nothing shifts.
- LOAD_LAT = 2, FWD_STAGES = 3, load followed by a use → 2 stall cycles, then fwd = 3. Reset asserted mid-stall → stall = 0 at once, and the counters clear.
